// File: rtl/tower_pkg.sv
// Shared types and cost table for the tower slot manager.
package tower_pkg;

   typedef enum logic [2:0] {
      TOWER_NONE = 3'd0,
      TOWER_T1   = 3'd1,
      TOWER_T2   = 3'd2,
      TOWER_T3   = 3'd3
   } tower_type_e;

   localparam logic [7:0] COST_T1 = 8'd100;
   localparam logic [7:0] COST_T2 = 8'd160;
   localparam logic [7:0] COST_T3 = 8'd220;

   typedef enum logic [1:0] {
      RC_OK            = 2'b00,
      RC_INVALID       = 2'b01,
      RC_SLOT_CONFLICT = 2'b10,
      RC_NO_GOLD       = 2'b11
   } resp_code_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   function automatic logic [7:0] tower_cost(input logic [2:0] t);
      case (t)
         TOWER_T1: return COST_T1;
         TOWER_T2: return COST_T2;
         TOWER_T3: return COST_T3;
         default:  return 8'd0;
      endcase
   endfunction

   function automatic logic type_is_valid(input logic [2:0] t);
      return (t == TOWER_T1) || (t == TOWER_T2) || (t == TOWER_T3);
   endfunction

endpackage

// File: rtl/gold_accumulator.sv
// Gold register: saturating add of refund and reward, minus a build cost, in one update.
module gold_accumulator #(
   parameter int GOLD_W     = 12,
   parameter int START_GOLD = 200
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              add_en,
   input  logic [7:0]        add_amt,
   input  logic              sub_en,
   input  logic [7:0]        sub_amt,
   input  logic              reward_valid,
   input  logic [7:0]        reward_amt,
   output logic [GOLD_W-1:0] gold
);

   localparam int SUM_W = GOLD_W + 2;
   localparam logic [SUM_W-1:0] GOLD_MAX = {2'b00, {GOLD_W{1'b1}}};

   logic [SUM_W-1:0]  add_ext;
   logic [SUM_W-1:0]  reward_ext;
   logic [SUM_W-1:0]  sum_up;
   logic [SUM_W-1:0]  sum_net;
   logic [GOLD_W-1:0] gold_d;

   // Subtract happens before saturation so a reward is never lost to a clipped intermediate.
   // The caller only subtracts when gold already covers the cost, so no underflow.
   always_comb begin
      add_ext    = add_en       ? {{(SUM_W-8){1'b0}}, add_amt}    : '0;
      reward_ext = reward_valid ? {{(SUM_W-8){1'b0}}, reward_amt} : '0;
      sum_up     = {2'b00, gold} + add_ext + reward_ext;
      sum_net    = sub_en ? (sum_up - {{(SUM_W-8){1'b0}}, sub_amt}) : sum_up;
      gold_d     = (sum_net > GOLD_MAX) ? GOLD_MAX[GOLD_W-1:0] : sum_net[GOLD_W-1:0];
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) gold <= GOLD_W'(START_GOLD);
      else          gold <= gold_d;
   end

endmodule

// File: rtl/tower_slot_manager.sv
// Build/sell command responder over 8 tower slots and the player's gold.
//  state | meaning
//  IDLE  | cmd_ready high, latch command on cmd_valid
//  EXEC  | validate latched command, commit if legal, latch result
//  RESP  | resp_valid strobe for one cycle
module tower_slot_manager
   import tower_pkg::*;
#(
   parameter int NUM_SLOTS  = 8,
   parameter int GOLD_W     = 12,
   parameter int START_GOLD = 200
) (
   input  logic                   Clk,
   input  logic                   Reset_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_build,
   input  logic                   cmd_sell,
   input  logic [2:0]             cmd_type,
   input  logic [2:0]             cmd_loc,
   input  logic                   reward_valid,
   input  logic [7:0]             reward_amt,
   output logic                   resp_valid,
   output logic                   resp_ok,
   output logic [1:0]             resp_code,
   output logic [GOLD_W-1:0]      gold,
   output logic [NUM_SLOTS-1:0]   occupied,
   output logic [3*NUM_SLOTS-1:0] slot_types
);

   localparam int LOC_W = $clog2(NUM_SLOTS);

   state_e            state_q, state_d;
   logic              build_q, sell_q;
   logic [2:0]        type_q, loc_q;
   logic [2:0]        slot_type_q [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] occ_q;
   logic              resp_ok_q;
   resp_code_e        resp_code_q;

   logic [LOC_W-1:0]  loc_idx;
   logic              loc_in_range;
   logic [2:0]        sel_type;
   logic              sel_occ;
   logic [7:0]        build_cost;
   resp_code_e        code_d;
   logic              commit;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (cmd_valid) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready  = (state_q == ST_IDLE);
      resp_valid = (state_q == ST_RESP);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         build_q <= 1'b0;
         sell_q  <= 1'b0;
         type_q  <= 3'd0;
         loc_q   <= 3'd0;
      end else if (state_q == ST_IDLE && cmd_valid) begin
         build_q <= cmd_build;
         sell_q  <= cmd_sell;
         type_q  <= cmd_type;
         loc_q   <= cmd_loc;
      end
   end

   // Slot lookups below are only meaningful once loc_in_range has passed.
   assign loc_idx      = loc_q[LOC_W-1:0];
   assign loc_in_range = (32'(loc_q) < NUM_SLOTS);
   assign sel_type     = slot_type_q[loc_idx];
   assign sel_occ      = occ_q[loc_idx];
   assign build_cost   = tower_cost(type_q);

   always_comb begin
      code_d = RC_OK;
      if ((build_q == sell_q) || (build_q && !type_is_valid(type_q)) || !loc_in_range)
         code_d = RC_INVALID;
      else if ((build_q && sel_occ) || (sell_q && !sel_occ))
         code_d = RC_SLOT_CONFLICT;
      else if (build_q && (gold < GOLD_W'(build_cost)))
         code_d = RC_NO_GOLD;
   end

   assign commit = (state_q == ST_EXEC) && (code_d == RC_OK);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < NUM_SLOTS; i++) slot_type_q[i] <= TOWER_NONE;
         occ_q <= '0;
      end else if (commit) begin
         if (build_q) begin
            slot_type_q[loc_idx] <= type_q;
            occ_q[loc_idx]       <= 1'b1;
         end else begin
            slot_type_q[loc_idx] <= TOWER_NONE;
            occ_q[loc_idx]       <= 1'b0;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         resp_ok_q   <= 1'b0;
         resp_code_q <= RC_OK;
      end else if (state_q == ST_EXEC) begin
         resp_ok_q   <= (code_d == RC_OK);
         resp_code_q <= code_d;
      end
   end

   gold_accumulator #(
      .GOLD_W     (GOLD_W),
      .START_GOLD (START_GOLD)
   ) u_gold (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .add_en       (commit && sell_q),
      .add_amt      (tower_cost(sel_type) >> 1),
      .sub_en       (commit && build_q),
      .sub_amt      (build_cost),
      .reward_valid (reward_valid),
      .reward_amt   (reward_amt),
      .gold         (gold)
   );

   always_comb begin
      slot_types = '0;
      for (int i = 0; i < NUM_SLOTS; i++) slot_types[3*i +: 3] = slot_type_q[i];
   end

   assign occupied  = occ_q;
   assign resp_ok   = resp_ok_q;
   assign resp_code = resp_code_q;

endmodule
